lbp_ctrl: RTL and testbench
===========================

LBP_CTRL -- requirements
Module: lbp_ctrl

Interface
REQ-001 Parameter IMG_W, default 128: image width and height in pixels (square image).
REQ-002 Parameter AW, default 14: address width; SHALL equal log2(IMG_W*IMG_W).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 gray_ready  input  1  gray image memory ready to serve requests.
REQ-006 gray_req  output  1  read request to gray memory.
REQ-007 gray_addr  output  AW  gray read address, row-major (y*IMG_W + x).
REQ-008 gray_data  input  8  gray pixel; valid on the cycle after the request.
REQ-009 reg0..reg8  output  8 each  3x3 window to the LBP PE, row-major: reg0=(y-1,x-1), reg4=centre, reg8=(y+1,x+1).
REQ-010 pe_lbp  input  8  combinational LBP code returned by the PE for the current window.
REQ-011 lbp_valid  output  1  write strobe to LBP result memory.
REQ-012 lbp_addr  output  AW  result address = centre address y*IMG_W + x.
REQ-013 lbp_data  output  8  result byte written.
REQ-014 finish  output  1  whole image processed.

Function
REQ-015 States: IDLE, FETCH, LAST, WRITE, DONE.
REQ-016 IDLE -> FETCH on the first cycle gray_ready is sampled high; gray_ready SHALL be ignored in every other state.
REQ-017 Centre scan: x and y each run 1..IMG_W-2; x increments fastest; border pixels SHALL never be written.
REQ-018 Full fetch (x=1): FETCH lasts 9 cycles, gray_req=1, addresses issued in order reg0..reg8.
REQ-019 Column fetch (x>1): on FETCH entry the window SHALL shift left (reg0<-reg1, reg1<-reg2, reg3<-reg4, reg4<-reg5, reg6<-reg7, reg7<-reg8); FETCH then lasts 3 cycles fetching column x+1 into reg2, reg5, reg8, in that order.
REQ-020 Capture pipelined: gray_data for the request issued in cycle t SHALL be stored into its window register at the end of cycle t+1; LAST (1 cycle, gray_req=0) captures the final pixel.
REQ-021 WRITE (1 cycle): lbp_valid=1, lbp_addr=centre, lbp_data=pe_lbp, reg0..reg8 stable.
REQ-022 Latency per centre: 11 cycles for x=1 (9+1+1), 5 cycles for x>1 (3+1+1).
REQ-023 After WRITE: if x<IMG_W-2, x+1 -> column FETCH; else if y<IMG_W-2, x=1, y+1 -> full FETCH; else -> DONE.
REQ-024 DONE: finish=1, gray_req=0, lbp_valid=0; held until reset.
REQ-025 gray_req and lbp_valid SHALL never be high in the same cycle.
REQ-026 Address arithmetic unsigned, AW bits, no wrap possible for legal x, y.
REQ-027 Total writes per image SHALL be exactly (IMG_W-2)^2 (15876 at default).

Reset
REQ-028 reset high SHALL, on the next edge, force IDLE, x=1, y=1, reg0..reg8=0, gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0.
REQ-029 Reset mid-FETCH or mid-WRITE SHALL abort with no further lbp_valid pulse; processing restarts from (1,1) after the next gray_ready.
REQ-030 Reset has priority over every other event in the same cycle.

Verification
REQ-031 gray_ready=1 after reset, memory of all 0x00 -> first gray_addr sequence 0,1,2,128,129,130,256,257,258; first lbp_valid at cycle 11 after FETCH entry, lbp_addr=129, lbp_data=pe_lbp.
REQ-032 Second centre -> gray_addr 3,131,259 only; lbp_valid 5 cycles after first; lbp_addr=130.
REQ-033 Row wrap: after lbp_addr=254 (x=126,y=1), next fetch is full 9-pixel at addresses 128,129,130,256,257,258,384,385,386; lbp_addr=257.
REQ-034 Full run, random image, golden PE model -> 15876 writes, last lbp_addr=16254, finish=1 on the cycle after that WRITE and held; no write to any border address.
REQ-035 reset asserted during the 5th cycle of a full FETCH -> all outputs 0 next cycle; gray_ready held low 10 cycles -> no gray_req; then high -> sequence restarts at gray_addr 0.
REQ-036 gray_ready toggled during processing -> no effect on gray_req, gray_addr or write timing.

Source files
------------

// File: rtl/lbp_if.sv
// Gray-memory read port and LBP-result write port between the controller and its memories.
interface lbp_if #(
   parameter int unsigned AW = 14
);
   logic          gray_ready;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [7:0]    gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [7:0]    lbp_data;

   modport master (
      input  gray_ready, gray_data,
      output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data
   );

   modport slave (
      output gray_ready, gray_data,
      input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data
   );
endinterface

// File: rtl/lbp_ctrl.sv
// LBP controller: scans every non-border centre of a square gray image, gathers its 3x3
// window (full fetch at x=1, one new column otherwise) and writes the PE result.
module lbp_ctrl #(
   parameter int unsigned IMG_W = 128,
   parameter int unsigned AW    = 14
) (
   input  logic       clk,
   input  logic       reset,
   lbp_if.master      bus,
   output logic [7:0] reg0,
   output logic [7:0] reg1,
   output logic [7:0] reg2,
   output logic [7:0] reg3,
   output logic [7:0] reg4,
   output logic [7:0] reg5,
   output logic [7:0] reg6,
   output logic [7:0] reg7,
   output logic [7:0] reg8,
   input  logic [7:0] pe_lbp,
   output logic       finish
);
   localparam int unsigned   CW     = $clog2(IMG_W);
   localparam logic [CW-1:0] XY_END = CW'(IMG_W - 2);

   typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] x, x_n, y, y_n;
   logic [1:0]    fr, fr_n, fc, fc_n;
   logic          shift_c;
   logic          cap_en;
   logic [3:0]    cap_idx;
   logic [7:0]    win [9];
   logic [AW-1:0] addr_c;
   logic          gray_req_q, lbp_valid_q, finish_q;
   logic [AW-1:0] gray_addr_q, lbp_addr_q;

   // fr/fc: window row/column of the request on the bus; column fetch pins fc at 2
   always_comb begin
      state_n = state;
      x_n     = x;
      y_n     = y;
      fr_n    = fr;
      fc_n    = fc;
      shift_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.gray_ready) begin
               state_n = FETCH;
               x_n     = CW'(1);
               y_n     = CW'(1);
               fr_n    = 2'd0;
               fc_n    = 2'd0;
            end
         end
         FETCH: begin
            if (fr == 2'd2 && fc == 2'd2) begin
               state_n = LAST;
            end else if (x == CW'(1)) begin
               if (fc == 2'd2) begin
                  fc_n = 2'd0;
                  fr_n = fr + 2'd1;
               end else begin
                  fc_n = fc + 2'd1;
               end
            end else begin
               fr_n = fr + 2'd1;
            end
         end
         LAST: state_n = WRITE;
         WRITE: begin
            if (x < XY_END) begin
               state_n = FETCH;
               x_n     = x + CW'(1);
               fr_n    = 2'd0;
               fc_n    = 2'd2;
               shift_c = 1'b1;
            end else if (y < XY_END) begin
               state_n = FETCH;
               x_n     = CW'(1);
               y_n     = y + CW'(1);
               fr_n    = 2'd0;
               fc_n    = 2'd0;
            end else begin
               state_n = DONE;
            end
         end
         DONE:    state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   // Address of the next cycle's request; only used when the next state is FETCH
   always_comb begin
      addr_c = (AW'(y_n) + AW'(fr_n) - AW'(1)) * AW'(IMG_W) + AW'(x_n) + AW'(fc_n) - AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         x           <= CW'(1);
         y           <= CW'(1);
         fr          <= 2'd0;
         fc          <= 2'd0;
         cap_en      <= 1'b0;
         cap_idx     <= 4'd0;
         for (int i = 0; i < 9; i++) win[i] <= 8'd0;
         gray_req_q  <= 1'b0;
         gray_addr_q <= '0;
         lbp_valid_q <= 1'b0;
         lbp_addr_q  <= '0;
         finish_q    <= 1'b0;
      end else begin
         state   <= state_n;
         x       <= x_n;
         y       <= y_n;
         fr      <= fr_n;
         fc      <= fc_n;
         // Data answers one cycle after its request, so the target index trails by one
         cap_en  <= (state == FETCH);
         cap_idx <= 4'(fr) * 4'd3 + 4'(fc);
         if (cap_en) begin
            win[cap_idx] <= bus.gray_data;
         end else if (shift_c) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[3] <= win[4];
            win[4] <= win[5];
            win[6] <= win[7];
            win[7] <= win[8];
         end
         gray_req_q  <= (state_n == FETCH);
         gray_addr_q <= (state_n == FETCH) ? addr_c : '0;
         lbp_valid_q <= (state_n == WRITE);
         if (state_n == WRITE) lbp_addr_q <= AW'(y) * AW'(IMG_W) + AW'(x);
         finish_q    <= (state_n == DONE);
      end
   end

   // The PE code is combinational on the window, which only completes at the end of LAST
   assign bus.lbp_data  = lbp_valid_q ? pe_lbp : 8'd0;
   assign bus.gray_req  = gray_req_q;
   assign bus.gray_addr = gray_addr_q;
   assign bus.lbp_valid = lbp_valid_q;
   assign bus.lbp_addr  = lbp_addr_q;
   assign finish        = finish_q;

   assign reg0 = win[0];
   assign reg1 = win[1];
   assign reg2 = win[2];
   assign reg3 = win[3];
   assign reg4 = win[4];
   assign reg5 = win[5];
   assign reg6 = win[6];
   assign reg7 = win[7];
   assign reg8 = win[8];
endmodule

// File: tb/tb_lbp_ctrl.sv
// Bench for lbp_ctrl on a 16x16 image: gray memory model, golden LBP PE and a write scoreboard.
module tb_lbp_ctrl;
   localparam int unsigned W  = 16;
   localparam int unsigned AW = 8;
   localparam int unsigned N  = (W - 2) * (W - 2);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   typedef struct {
      logic          rdy;
      logic          req;
      logic [AW-1:0] addr;
      logic          vld;
      logic [AW-1:0] laddr;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, reg8;
   logic [7:0] pe_lbp;
   logic       finish;
   logic [7:0] mem [W*W];
   wr_t        sb [$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_wr    = 0;
   logic [AW-1:0] last_addr;

   lbp_if #(.AW(AW)) bus();

   lbp_ctrl #(.IMG_W(W), .AW(AW)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4),
      .reg5(reg5), .reg6(reg6), .reg7(reg7), .reg8(reg8),
      .pe_lbp(pe_lbp), .finish(finish)
   );

   always #5 clk = ~clk;

   // Gray memory: data for a request appears the following cycle
   always @(posedge clk) if (bus.gray_req) bus.gray_data <= mem[bus.gray_addr];

   function automatic logic [7:0] lbp_fn(input logic [71:0] w);
      logic [7:0] c, r;
      int b;
      c = w[4*8 +: 8];
      b = 0;
      r = 8'd0;
      for (int k = 0; k < 9; k++) begin
         if (k != 4) begin
            r[b] = (w[k*8 +: 8] >= c);
            b++;
         end
      end
      return r;
   endfunction

   assign pe_lbp = lbp_fn({reg8, reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0});

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected writes for the whole image, in scan order
   task automatic push_image();
      logic [71:0] w;
      sb.delete();
      n_wr = 0;
      for (int y = 1; y <= W - 2; y++) begin
         for (int x = 1; x <= W - 2; x++) begin
            for (int k = 0; k < 9; k++) w[k*8 +: 8] = mem[(y - 1 + k / 3) * W + x - 1 + k % 3];
            sb.push_back('{addr: AW'(y * W + x), data: lbp_fn(w)});
         end
      end
   endtask

   task automatic step();
      wr_t e;
      int  xx, yy;
      @(posedge clk);
      @(negedge clk);
      chk("req_valid_exclusive", 32'(bus.gray_req & bus.lbp_valid), 0);
      if (bus.lbp_valid) begin
         n_wr++;
         last_addr = bus.lbp_addr;
         xx = int'(bus.lbp_addr) % W;
         yy = int'(bus.lbp_addr) / W;
         chk("no_border_write", 32'(xx == 0 || xx == W - 1 || yy == 0 || yy == W - 1), 0);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d with empty scoreboard", bus.lbp_addr);
         end else begin
            e = sb.pop_front();
            chk("write_addr", 32'(bus.lbp_addr), 32'(e.addr));
            chk("write_data", 32'(bus.lbp_data), 32'(e.data));
         end
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_gray_req"},  32'(bus.gray_req), 0);
      chk({name, "_gray_addr"}, 32'(bus.gray_addr), 0);
      chk({name, "_lbp_valid"}, 32'(bus.lbp_valid), 0);
      chk({name, "_lbp_addr"},  32'(bus.lbp_addr), 0);
      chk({name, "_lbp_data"},  32'(bus.lbp_data), 0);
      chk({name, "_finish"},    32'(finish), 0);
      chk({name, "_window"},    32'(reg0 | reg1 | reg2 | reg3 | reg4 | reg5 | reg6 | reg7 | reg8), 0);
   endtask

   initial begin
      vec_t tbl [16];
      logic found, prev_v;
      int   cnt;

      // First centre (full fetch) then second centre (column fetch); ready toggles freely
      for (int k = 0; k < 9; k++)
         tbl[k] = '{rdy: 1'(k % 2 == 0), req: 1'b1, addr: AW'((k / 3) * W + k % 3), vld: 1'b0, laddr: '0};
      tbl[9]  = '{rdy: 1'b0, req: 1'b0, addr: '0, vld: 1'b0, laddr: '0};
      tbl[10] = '{rdy: 1'b1, req: 1'b0, addr: '0, vld: 1'b1, laddr: AW'(W + 1)};
      for (int j = 0; j < 3; j++)
         tbl[11 + j] = '{rdy: 1'(j % 2), req: 1'b1, addr: AW'(j * W + 3), vld: 1'b0, laddr: '0};
      tbl[14] = '{rdy: 1'b1, req: 1'b0, addr: '0, vld: 1'b0, laddr: '0};
      tbl[15] = '{rdy: 1'b0, req: 1'b0, addr: '0, vld: 1'b1, laddr: AW'(W + 2)};

      reset = 1'b1;
      bus.gray_ready = 1'b0;
      for (int i = 0; i < W * W; i++) mem[i] = 8'd0;
      repeat (2) step();
      chk_zero("reset");

      reset = 1'b0;
      repeat (3) begin
         step();
         chk("idle_no_req", 32'(bus.gray_req), 0);
      end

      for (int i = 0; i < W * W; i++) mem[i] = 8'($urandom);
      push_image();

      for (int i = 0; i < 16; i++) begin
         bus.gray_ready = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d_req", i), 32'(bus.gray_req), 32'(tbl[i].req));
         if (tbl[i].req) chk($sformatf("vec%0d_addr", i), 32'(bus.gray_addr), 32'(tbl[i].addr));
         chk($sformatf("vec%0d_valid", i), 32'(bus.lbp_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("vec%0d_laddr", i), 32'(bus.lbp_addr), 32'(tbl[i].laddr));
      end

      // Row wrap: after the last centre of row 1 a full fetch of rows 1..3 follows
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         bus.gray_ready = 1'($urandom);
         step();
         if (bus.lbp_valid && bus.lbp_addr == AW'(2 * W - 2)) found = 1'b1;
      end
      chk("row_end_seen", 32'(found), 1);
      for (int k = 0; k < 9; k++) begin
         step();
         chk("wrap_req", 32'(bus.gray_req), 1);
         chk($sformatf("wrap_addr%0d", k), 32'(bus.gray_addr), 32'(W + (k / 3) * W + k % 3));
      end
      step();
      chk("wrap_last_no_req", 32'(bus.gray_req), 0);
      step();
      chk("wrap_valid", 32'(bus.lbp_valid), 1);
      chk("wrap_laddr", 32'(bus.lbp_addr), 32'(2 * W + 1));

      // Run to completion; finish must follow the final write directly
      prev_v = 1'b0;
      for (int c = 0; c < 20000 && !finish; c++) begin
         prev_v = bus.lbp_valid;
         bus.gray_ready = 1'($urandom);
         step();
      end
      chk("finish_seen", 32'(finish), 1);
      chk("finish_after_write", 32'(prev_v), 1);
      chk("write_count", 32'(n_wr), N);
      chk("last_addr", 32'(last_addr), (W - 2) * W + W - 2);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      repeat (5) begin
         bus.gray_ready = 1'($urandom);
         step();
         chk("done_finish", 32'(finish), 1);
         chk("done_no_req", 32'(bus.gray_req), 0);
         chk("done_no_valid", 32'(bus.lbp_valid), 0);
      end

      // Reset during the 5th cycle of a full fetch, then restart
      reset = 1'b1;
      bus.gray_ready = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < W * W; i++) mem[i] = 8'($urandom);
      push_image();
      bus.gray_ready = 1'b1;
      step();
      chk("abort_first_addr", 32'(bus.gray_addr), 0);
      bus.gray_ready = 1'b0;
      repeat (4) step();
      chk("abort_cycle5_addr", 32'(bus.gray_addr), W + 1);
      reset = 1'b1;
      step();
      chk_zero("abort");
      reset = 1'b0;
      repeat (10) begin
         step();
         chk("abort_idle_no_req", 32'(bus.gray_req), 0);
         chk("abort_idle_no_valid", 32'(bus.lbp_valid), 0);
      end
      bus.gray_ready = 1'b1;
      step();
      chk("restart_req", 32'(bus.gray_req), 1);
      chk("restart_addr", 32'(bus.gray_addr), 0);
      bus.gray_ready = 1'b0;
      cnt = 0;
      while (!bus.lbp_valid && cnt < 20) begin
         step();
         cnt++;
      end
      chk("restart_latency", 32'(cnt), 10);
      chk("restart_laddr", 32'(bus.lbp_addr), W + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
